// File: rtl/perceptron_sample_loader.sv
// Training-set loader: captures a byte stream into a sample buffer, then replays
// every sample in order for EPOCHS passes over a valid/ready beat interface.
module perceptron_sample_loader #(
    parameter int N_SAMPLES = 3,
    parameter int DIM       = 2,
    parameter int EPOCHS    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               load,
    input  logic               start,
    output logic               s_valid,
    input  logic               s_ready,
    output logic [4*DIM-1:0]   s_x,
    output logic               s_label,
    output logic               s_last,
    output logic               s_epoch_last,
    output logic               done,
    output logic               fmt_err
);

    localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
    localparam int DW = $clog2(DIM + 1);

    localparam logic [SW-1:0] LAST_SAMP  = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0] LAST_EPOCH = EW'(EPOCHS - 1);
    localparam logic [DW-1:0] LABEL_SLOT = DW'(DIM);

    typedef enum logic [1:0] {
        LOAD,
        LOADED,
        STREAM,
        DONE
    } state_t;

    state_t               r_state;
    logic [4*DIM-1:0]     r_feat [N_SAMPLES];
    logic [N_SAMPLES-1:0] r_label;
    logic [DW-1:0]        r_dim_idx;
    logic [SW-1:0]        r_samp_idx;
    logic [SW-1:0]        r_ptr;
    logic [EW-1:0]        r_epoch;

    logic [SW-1:0]        w_beat_ptr;
    logic [EW-1:0]        w_beat_epoch;
    logic                 w_final_beat;
    logic                 w_clear;

    // Pointer/epoch of the beat to present next; outside STREAM that is the first beat.
    always_comb begin
        w_beat_ptr   = '0;
        w_beat_epoch = '0;
        w_final_beat = (r_ptr == LAST_SAMP) && (r_epoch == LAST_EPOCH);
        if (r_state == STREAM) begin
            w_beat_ptr   = (r_ptr == LAST_SAMP) ? '0 : r_ptr + 1'b1;
            w_beat_epoch = (r_ptr == LAST_SAMP) ? r_epoch + 1'b1 : r_epoch;
        end
    end

    // A load request from LOADED/DONE restores exactly the reset state.
    assign w_clear = !rst_n || (load && (r_state == LOADED || r_state == DONE));

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= LOAD;
            for (int unsigned i = 0; i < N_SAMPLES; i++) r_feat[i] <= '0;
            r_label      <= '0;
            r_dim_idx    <= '0;
            r_samp_idx   <= '0;
            r_ptr        <= '0;
            r_epoch      <= '0;
            fmt_err      <= 1'b0;
            in_ready     <= 1'b1;
            s_valid      <= 1'b0;
            s_x          <= '0;
            s_label      <= 1'b0;
            s_last       <= 1'b0;
            s_epoch_last <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        if (r_dim_idx == LABEL_SLOT) begin
                            r_label[r_samp_idx] <= in_data[0];
                            if (|in_data[7:1]) fmt_err <= 1'b1;
                            r_dim_idx <= '0;
                            if (r_samp_idx == LAST_SAMP) begin
                                r_samp_idx <= '0;
                                r_state    <= LOADED;
                                in_ready   <= 1'b0;
                            end else begin
                                r_samp_idx <= r_samp_idx + 1'b1;
                            end
                        end else begin
                            r_feat[r_samp_idx][4*r_dim_idx +: 4] <= in_data[3:0];
                            if (|in_data[7:4]) fmt_err <= 1'b1;
                            r_dim_idx <= r_dim_idx + 1'b1;
                        end
                    end
                end
                LOADED, DONE: begin
                    if (start) begin
                        r_state      <= STREAM;
                        r_ptr        <= '0;
                        r_epoch      <= '0;
                        s_valid      <= 1'b1;
                        s_x          <= r_feat[w_beat_ptr];
                        s_label      <= r_label[w_beat_ptr];
                        s_last       <= (w_beat_ptr == LAST_SAMP);
                        s_epoch_last <= (w_beat_epoch == LAST_EPOCH);
                        done         <= 1'b0;
                    end
                end
                STREAM: begin
                    if (s_ready) begin
                        if (w_final_beat) begin
                            r_state      <= DONE;
                            s_valid      <= 1'b0;
                            s_x          <= '0;
                            s_label      <= 1'b0;
                            s_last       <= 1'b0;
                            s_epoch_last <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            r_ptr        <= w_beat_ptr;
                            r_epoch      <= w_beat_epoch;
                            s_x          <= r_feat[w_beat_ptr];
                            s_label      <= r_label[w_beat_ptr];
                            s_last       <= (w_beat_ptr == LAST_SAMP);
                            s_epoch_last <= (w_beat_epoch == LAST_EPOCH);
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Directed bench for perceptron_sample_loader with hand-computed beat sequences.
module tb_perceptron_sample_loader;

    localparam int N     = 3;
    localparam int D     = 2;
    localparam int E     = 8;
    localparam int BEATS = N * E;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         load = 1'b0;
    logic         start = 1'b0;
    logic         s_valid;
    logic         s_ready = 1'b0;
    logic [4*D-1:0] s_x;
    logic         s_label;
    logic         s_last;
    logic         s_epoch_last;
    logic         done;
    logic         fmt_err;

    always #5 clk = ~clk;

    perceptron_sample_loader #(
        .N_SAMPLES(N),
        .DIM      (D),
        .EPOCHS   (E)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .load        (load),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_x         (s_x),
        .s_label     (s_label),
        .s_last      (s_last),
        .s_epoch_last(s_epoch_last),
        .done        (done),
        .fmt_err     (fmt_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] std_bytes [9];
    logic [7:0] exp_x [3];
    logic       exp_l [3];

    logic [7:0] cap_x [$];
    logic       cap_l [$];
    logic       cap_last [$];
    logic       cap_el [$];
    int         done_gap;
    int         stall_viol;
    int         idle_viol;
    bit         fmt_seen;
    bit         timed_out;

    task automatic send_range(input logic [7:0] first, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? first : std_bytes[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Records every handshaken beat until done, plus stall/idle/fmt observations.
    task automatic collect(input bit bp, input int start_at);
        int         since;
        bit         stalled;
        logic [11:0] held;
        cap_x.delete(); cap_l.delete(); cap_last.delete(); cap_el.delete();
        stall_viol = 0; idle_viol = 0; fmt_seen = 1'b0; done_gap = -1;
        timed_out = 1'b1; since = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            start = (start_at >= 0) && (cap_x.size() == start_at);
            if (fmt_err) fmt_seen = 1'b1;
            if (!s_valid && (s_x !== '0 || s_label || s_last || s_epoch_last)) idle_viol++;
            if (stalled && ({s_valid, s_x, s_label, s_last, s_epoch_last} !== held)) stall_viol++;
            if (done) begin
                done_gap  = since;
                timed_out = 1'b0;
                break;
            end
            s_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_valid && s_ready) begin
                cap_x.push_back(s_x);
                cap_l.push_back(s_label);
                cap_last.push_back(s_last);
                cap_el.push_back(s_epoch_last);
                since = 0;
            end
            stalled = s_valid && !s_ready;
            held    = {s_valid, s_x, s_label, s_last, s_epoch_last};
            @(negedge clk);
            since++;
        end
        start   = 1'b0;
        s_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, s_valid, s_x, s_label, s_last, s_epoch_last, done, fmt_err} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got %b required %b",
                     {in_ready, s_valid, s_x, s_label, s_last, s_epoch_last, done, fmt_err},
                     {1'b1, 1'b0, 8'h00, 5'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_range(8'h02, 0, 8);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_mid: got %b required 1", in_ready); end
        send_range(8'h02, 8, 9);
        vectors++;
        if ({in_ready, s_valid, done} !== 3'b000) begin
            miscompares++; $display("FAIL basic_loaded: got %b required 000", {in_ready, s_valid, done});
        end
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        vectors++;
        if ({fmt_err, in_ready} !== 2'b00) begin
            miscompares++; $display("FAIL basic_ignored_byte: got %b required 00", {fmt_err, in_ready});
        end
        pulse_start();
        vectors++;
        if (s_valid !== 1'b1) begin miscompares++; $display("FAIL basic_first_beat_latency: got %b required 1", s_valid); end
        collect(1'b0, -1);
        vectors++;
        if (timed_out || cap_x.size() != BEATS) begin
            miscompares++; $display("FAIL basic_count: got %0d timeout=%0d required %0d", cap_x.size(), timed_out, BEATS);
        end
        for (int i = 0; i < BEATS && i < cap_x.size(); i++) begin
            vectors++;
            if ({cap_x[i], cap_l[i], cap_last[i], cap_el[i]} !== {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)}) begin
                miscompares++;
                $display("FAIL basic_beat %0d: got %h required %h", i, {cap_x[i], cap_l[i], cap_last[i], cap_el[i]},
                         {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)});
            end
        end
        vectors++;
        if (done_gap != 1) begin miscompares++; $display("FAIL basic_done_gap: got %0d required 1", done_gap); end
        vectors++;
        if (fmt_seen || idle_viol != 0) begin
            miscompares++; $display("FAIL basic_fmt_idle: got fmt=%0d idle=%0d required 0 0", fmt_seen, idle_viol);
        end
        vectors++;
        if ({s_valid, done} !== 2'b01) begin miscompares++; $display("FAIL basic_done_state: got %b required 01", {s_valid, done}); end
    endtask

    task automatic test_backpressure();
        pulse_load();
        vectors++;
        if ({in_ready, done} !== 2'b10) begin miscompares++; $display("FAIL bp_reload: got %b required 10", {in_ready, done}); end
        send_range(8'h02, 0, 9);
        pulse_start();
        collect(1'b1, -1);
        vectors++;
        if (timed_out || cap_x.size() != BEATS) begin
            miscompares++; $display("FAIL bp_count: got %0d timeout=%0d required %0d", cap_x.size(), timed_out, BEATS);
        end
        for (int i = 0; i < BEATS && i < cap_x.size(); i++) begin
            vectors++;
            if ({cap_x[i], cap_l[i], cap_last[i], cap_el[i]} !== {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)}) begin
                miscompares++;
                $display("FAIL bp_beat %0d: got %h required %h", i, {cap_x[i], cap_l[i], cap_last[i], cap_el[i]},
                         {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)});
            end
        end
        vectors++;
        if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stall_hold: got %0d changes required 0", stall_viol); end
        vectors++;
        if (done_gap != 1) begin miscompares++; $display("FAIL bp_done_gap: got %0d required 1", done_gap); end
    endtask

    task automatic test_fmt_err();
        pulse_load();
        send_range(8'h12, 0, 1);
        vectors++;
        if (fmt_err !== 1'b1) begin miscompares++; $display("FAIL fmt_feature_flag: got %b required 1", fmt_err); end
        send_range(8'h12, 1, 9);
        pulse_start();
        collect(1'b0, -1);
        vectors++;
        if (cap_x.size() == 0 || cap_x[0] !== 8'h32 || cap_l[0] !== 1'b0 || !fmt_seen) begin
            miscompares++; $display("FAIL fmt_feature_stored: got size=%0d sticky=%0d required x=32 label=0 sticky=1", cap_x.size(), fmt_seen);
        end
        pulse_load();
        vectors++;
        if (fmt_err !== 1'b0) begin miscompares++; $display("FAIL fmt_clear_1: got %b required 0", fmt_err); end
        send_range(8'h02, 0, 2);
        in_valid = 1'b1; in_data = 8'h03;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        vectors++;
        if (fmt_err !== 1'b1) begin miscompares++; $display("FAIL fmt_label_flag: got %b required 1", fmt_err); end
        send_range(8'h02, 3, 9);
        pulse_start();
        collect(1'b0, -1);
        vectors++;
        if (cap_x.size() == 0 || cap_x[0] !== 8'h32 || cap_l[0] !== 1'b1) begin
            miscompares++; $display("FAIL fmt_label_stored: got size=%0d required x=32 label=1", cap_x.size());
        end
        pulse_load();
        vectors++;
        if (fmt_err !== 1'b0) begin miscompares++; $display("FAIL fmt_clear_2: got %b required 0", fmt_err); end
    endtask

    task automatic test_reset_mid();
        send_range(8'h0F, 0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready, s_valid, fmt_err} !== 3'b100) begin
            miscompares++; $display("FAIL rstmid_after: got %b required 100", {in_ready, s_valid, fmt_err});
        end
        send_range(8'h02, 0, 8);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_mid: got %b required 1", in_ready); end
        send_range(8'h02, 8, 9);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_loaded: got %b required 0", in_ready); end
        pulse_start();
        collect(1'b0, -1);
        vectors++;
        if (timed_out || cap_x.size() != BEATS) begin
            miscompares++; $display("FAIL rstmid_count: got %0d required %0d", cap_x.size(), BEATS);
        end
        for (int i = 0; i < BEATS && i < cap_x.size(); i++) begin
            vectors++;
            if ({cap_x[i], cap_l[i], cap_last[i], cap_el[i]} !== {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)}) begin
                miscompares++;
                $display("FAIL rstmid_beat %0d: got %h required %h", i, {cap_x[i], cap_l[i], cap_last[i], cap_el[i]},
                         {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)});
            end
        end
    endtask

    task automatic test_simultaneous();
        load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        vectors++;
        if ({s_valid, in_ready, done} !== 3'b010) begin
            miscompares++; $display("FAIL simul_to_load: got %b required 010", {s_valid, in_ready, done});
        end
        @(negedge clk);
        vectors++;
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL simul_stays_idle: got %b required 0", s_valid); end
        send_range(8'h02, 0, 9);
        for (int run = 0; run < 2; run++) begin
            pulse_start();
            collect(1'b0, -1);
            vectors++;
            if (timed_out || cap_x.size() != BEATS || done_gap != 1) begin
                miscompares++; $display("FAIL simul_run%0d_count: got %0d gap=%0d required %0d gap=1", run, cap_x.size(), done_gap, BEATS);
            end
            for (int i = 0; i < BEATS && i < cap_x.size(); i++) begin
                vectors++;
                if ({cap_x[i], cap_l[i], cap_last[i], cap_el[i]} !== {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)}) begin
                    miscompares++;
                    $display("FAIL simul_run%0d_beat %0d: got %h required %h", run, i, {cap_x[i], cap_l[i], cap_last[i], cap_el[i]},
                             {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)});
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        pulse_start();
        collect(1'b0, 5);
        vectors++;
        if (timed_out || cap_x.size() != BEATS) begin
            miscompares++; $display("FAIL ignstart_count: got %0d required %0d", cap_x.size(), BEATS);
        end
        for (int i = 0; i < BEATS && i < cap_x.size(); i++) begin
            vectors++;
            if ({cap_x[i], cap_l[i], cap_last[i], cap_el[i]} !== {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)}) begin
                miscompares++;
                $display("FAIL ignstart_beat %0d: got %h required %h", i, {cap_x[i], cap_l[i], cap_last[i], cap_el[i]},
                         {exp_x[i%3], exp_l[i%3], (i % 3 == 2), (i >= BEATS - 3)});
            end
        end
        pulse_load();
        pulse_start();
        vectors++;
        if ({s_valid, in_ready} !== 2'b01) begin
            miscompares++; $display("FAIL ignstart_in_load: got %b required 01", {s_valid, in_ready});
        end
    endtask

    initial begin
        std_bytes = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
        exp_x     = '{8'h32, 8'h54, 8'h21};
        exp_l     = '{1'b0, 1'b1, 1'b1};
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_fmt_err();
        test_reset_mid();
        test_simultaneous();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end

endmodule

// File: doc/perceptron_sample_loader.md
# perceptron_sample_loader

Upstream feeder for the perceptron training stage. Accepts a training set as a byte stream over a valid/ready input, stores it in an internal sample buffer, and on `start` replays every sample in order for a fixed number of epochs over a valid/ready output. Each output beat carries one sample's 4-bit features and its label, plus last-sample and last-epoch markers that the trainer consumes.

## Interface
Parameters:
- `N_SAMPLES`, default 3: samples in the training set, ≥1.
- `DIM`, default 2: features per sample, ≥1.
- `EPOCHS`, default 8: replay passes per `start`, ≥1.

Ports (reset `rst_n` is synchronous and active-low; clock is `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  8  input byte.
- `load`  in  1  pulse: discard the buffer and begin a new load.
- `start`  in  1  pulse: begin replay of the loaded set.
- `s_valid`  out  1  sample beat valid.
- `s_ready`  in  1  trainer accepts the beat.
- `s_x`  out  4*DIM  features; feature d is at `[4d+3:4d]`.
- `s_label`  out  1  target label.
- `s_last`  out  1  beat is sample N_SAMPLES-1.
- `s_epoch_last`  out  1  beat belongs to the final epoch.
- `done`  out  1  high while in DONE.
- `fmt_err`  out  1  sticky format-error flag.

## Operation
- States: LOAD, LOADED, STREAM, DONE. Reset enters LOAD.
- Reset also clears the buffer, all counters, and `fmt_err`.
- **Load byte order.** Sample 0 to N_SAMPLES-1. Each sample is DIM feature bytes (feature 0 first), then one label byte. Total bytes = N_SAMPLES*(DIM+1).
- **Storage.**
  - A feature byte stores `in_data[3:0]`. If `in_data[7:4]` is not 0, set `fmt_err`.
  - A label byte stores `in_data[0]`. If `in_data[7:1]` is not 0, set `fmt_err`.
  - The byte is stored either way.
- **LOAD.** `in_ready`=1. A byte is accepted on any edge with `in_valid && in_ready`. Counters `dim_idx` (0..DIM, where DIM means the label slot) and `samp_idx` advance on each accepted byte. Accepting the final label byte moves the FSM to LOADED.
- **LOADED.** `in_ready`=0.
  - `start` goes to STREAM, with sample pointer and epoch counter set to 0.
  - `load` goes to LOAD, clearing the buffer, counters, and `fmt_err`.
  - If `load` and `start` arrive in the same cycle, `load` wins.
- **STREAM.**
  - `s_valid`=1. `s_x`/`s_label` come from `buffer[ptr]`.
  - `s_last` = (ptr == N_SAMPLES-1).
  - `s_epoch_last` = (epoch == EPOCHS-1).
  - On `s_valid && s_ready`, ptr increments. When ptr wraps from N_SAMPLES-1 to 0, epoch increments.
  - A handshake on the beat with both `s_last` and `s_epoch_last` high moves the FSM to DONE.
  - `start` and `load` are ignored.
- **DONE.** `done`=1.
  - `start` replays the same buffer (goes to STREAM, ptr and epoch set to 0).
  - `load` goes to LOAD.
  - If both arrive in the same cycle, `load` wins.
- **Idle outputs.** `s_x`, `s_label`, `s_last`, `s_epoch_last` are 0 whenever `s_valid`=0.
- **Ignored inputs.** `start` in LOAD is ignored. `in_valid` outside LOAD is ignored, with no side effects.
- **Reset mid-operation.** Any state, including a partial load or mid-stream, goes to LOAD with the buffer cleared. No partial beat is completed.

## Timing
- **Reset values:** `in_ready`=1, `s_valid`=0, `s_x`=0, `s_label`=0, `s_last`=0, `s_epoch_last`=0, `done`=0, `fmt_err`=0.
- **Decode.** All outputs are decoded from registered state, pointer and buffer. There is no combinational path from `s_ready` or `in_valid` to any output.
- **Input side.** One byte per cycle sustained. `in_ready` drops the cycle after the final byte is accepted.
- **Start to first beat.** `start` sampled at edge k gives `s_valid`=1 from cycle k+1.
- **Output throughput.** One beat per cycle while `s_ready`=1. A full run takes N_SAMPLES*EPOCHS handshakes.
- **Backpressure.** While `s_valid && !s_ready`, all `s_*` outputs hold stable.
- **Entry to DONE.** `s_valid` falls and `done` rises in the cycle after the final handshake.
- **`fmt_err` timing.** It is visible the cycle after the offending byte is accepted.

## Test plan
- **Basic load and replay.** Defaults (N=3, D=2, E=8). Load bytes 02 03 00 04 05 01 01 02 01, then pulse `start`, with `s_ready`=1.
  - Expect 24 beats: `s_x` = {3,2}, {5,4}, {2,1} (packed 0x32, 0x54, 0x21) with labels 0, 1, 1, repeating.
  - `s_last` is high on every 3rd beat.
  - `s_epoch_last` is high on beats 22–24.
  - `done` rises 1 cycle after beat 24, and `fmt_err`=0 throughout.
- **Backpressure.** Same load, with `s_ready` toggling randomly.
  - Outputs are held stable during stalls.
  - The beat sequence is identical to the basic case, with no beat lost or duplicated.
- **Format error.** Load with the first byte = 0x12.
  - `fmt_err`=1 from the next cycle.
  - Stored feature = 2, so the first beat carries `s_x[3:0]`=2.
  - A subsequent `load` clears `fmt_err`.
- **Reset mid-operation.** Assert `rst_n`=0 after 4 bytes of a load, then reload the full set.
  - Loading restarts at sample 0, feature 0.
  - `in_ready`=1 on the first cycle after reset.
- **Simultaneous control.** In DONE, pulse `load` and `start` in the same cycle: FSM goes to LOAD, `s_valid` stays 0. Then load fully and pulse `start` twice: the second run is identical to the first.
- **Ignored `start` mid-stream.** Pulse `start` during STREAM: no restart, and the beat count is still 24.
